// File: rtl/idma_legalizer_rw_axi_flex.sv
// idma_legalizer_rw_axi_flex: splits 1D transfers into AXI4 AR/AW bursts; `IDMA_LEGALIZER_FIXED_BURST_EN enables FIXED bursts.
module idma_legalizer_rw_axi_flex #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned LenWidth  = 32,
  parameter int unsigned MaxBeats  = 256,
  parameter int unsigned PageSize  = 4096,
  localparam int unsigned StrbWidth   = DataWidth / 8,
  localparam int unsigned OffsetWidth = $clog2(StrbWidth)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   req_src_addr_i,
  input  logic [AddrWidth-1:0]   req_dst_addr_i,
  input  logic [LenWidth-1:0]    req_length_i,
  input  logic                   req_decouple_rw_i,
  input  logic                   req_fixed_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  output logic [AddrWidth-1:0]   r_addr_o,
  output logic [7:0]             r_len_o,
  output logic [OffsetWidth-1:0] r_offset_o,
  output logic [OffsetWidth-1:0] r_tailer_o,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [AddrWidth-1:0]   w_addr_o,
  output logic [7:0]             w_len_o,
  output logic [OffsetWidth-1:0] w_offset_o,
  output logic [OffsetWidth-1:0] w_tailer_o,
  output logic                   w_last_o,
  output logic                   w_valid_o,
  input  logic                   w_ready_i,
  input  logic                   flush_i,
  input  logic                   kill_i,
  output logic                   r_busy_o,
  output logic                   w_busy_o
);
  localparam int unsigned BeatBytes  = MaxBeats * StrbWidth;
  localparam int unsigned BurstBytes = PageSize < BeatBytes ? PageSize : BeatBytes;
  localparam int unsigned FixedBytes = (MaxBeats < 16 ? MaxBeats : 16) * StrbWidth;
  typedef enum logic {IDLE, ISSUE} state_e;
  state_e               state_q [2];
  state_e               state_d [2];
  logic [AddrWidth-1:0] addr_q [2];
  logic [AddrWidth-1:0] addr_d [2];
  logic [LenWidth-1:0]  rem_q [2];
  logic [LenWidth-1:0]  rem_d [2];
  logic [LenWidth-1:0]  lim [2];
  logic [LenWidth-1:0]  bytes [2];
  logic [LenWidth-1:0]  c_lim;
  logic [7:0]           len [2];
  logic [OffsetWidth-1:0] off [2];
  logic [OffsetWidth-1:0] tail [2];
  logic [1:0] valid_q, valid_d, acc_q, acc_d, hs, done, adv, fin, free;
  logic decouple_q, fixed_q, accept, nonzero;
`ifdef IDMA_LEGALIZER_FIXED_BURST_EN
  localparam bit FixedEn = 1'b1;
  a_fixed_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (accept && req_fixed_i) |-> (req_src_addr_i[OffsetWidth-1:0] == '0 && req_dst_addr_i[OffsetWidth-1:0] == '0));
`else
  localparam bit FixedEn = 1'b0;
  a_no_fixed: assert property (@(posedge clk_i) disable iff (!rst_ni) !(accept && req_fixed_i));
`endif
  function automatic logic [LenWidth-1:0] min_len(input logic [LenWidth-1:0] a, input logic [LenWidth-1:0] b);
    return a < b ? a : b;
  endfunction
  always_comb begin
    for (int c = 0; c < 2; c++)
      lim[c] = fixed_q ? LenWidth'(FixedBytes)
                       : LenWidth'(BurstBytes) - LenWidth'(addr_q[c] & AddrWidth'(BurstBytes - 1));
  end
  assign c_lim = min_len(lim[0], lim[1]);
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      bytes[c] = min_len(rem_q[c], decouple_q ? lim[c] : c_lim);
      off[c]   = addr_q[c][OffsetWidth-1:0];
      len[c]   = bytes[c] == '0 ? 8'd0 : 8'((LenWidth'(off[c]) + bytes[c] - LenWidth'(1)) >> OffsetWidth);
      tail[c]  = off[c] + bytes[c][OffsetWidth-1:0];
    end
  end
  // coupled channels advance together once both bursts have been taken
  assign hs   = valid_q & {w_ready_i, r_ready_i};
  assign done = acc_q | hs;
  assign adv  = decouple_q ? hs : {2{&done}};
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      fin[c]  = adv[c] & (rem_q[c] == bytes[c]);
      free[c] = (state_q[c] == IDLE) | fin[c];
    end
  end
  assign req_ready_o = &free & !flush_i & !kill_i;
  assign accept      = req_valid_i & req_ready_o;
  assign nonzero     = req_length_i != '0;
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      state_d[c] = state_q[c];
      addr_d[c]  = addr_q[c];
      rem_d[c]   = rem_q[c];
      acc_d[c]   = acc_q[c];
      if (adv[c]) begin
        addr_d[c]  = fixed_q ? addr_q[c] : addr_q[c] + AddrWidth'(bytes[c]);
        rem_d[c]   = rem_q[c] - bytes[c];
        acc_d[c]   = 1'b0;
        state_d[c] = fin[c] ? IDLE : ISSUE;
      end else if (hs[c]) begin
        acc_d[c] = 1'b1;
      end
      if (accept) begin
        state_d[c] = nonzero ? ISSUE : IDLE;
        addr_d[c]  = c == 0 ? req_src_addr_i : req_dst_addr_i;
        rem_d[c]   = req_length_i;
        acc_d[c]   = 1'b0;
      end
      if (kill_i) begin
        state_d[c] = IDLE;
        rem_d[c]   = '0;
        acc_d[c]   = 1'b0;
      end
      valid_d[c] = !kill_i & ((valid_q[c] & !hs[c]) | (!flush_i & state_d[c] == ISSUE & !acc_d[c]));
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= IDLE;
        addr_q[c]  <= '0;
        rem_q[c]   <= '0;
      end
      valid_q    <= '0;
      acc_q      <= '0;
      decouple_q <= 1'b0;
      fixed_q    <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= state_d[c];
        addr_q[c]  <= addr_d[c];
        rem_q[c]   <= rem_d[c];
      end
      valid_q <= valid_d;
      acc_q   <= acc_d;
      if (accept) begin
        decouple_q <= req_decouple_rw_i;
        fixed_q    <= FixedEn & req_fixed_i;
      end
    end
  end
  assign r_addr_o   = {addr_q[0][AddrWidth-1:OffsetWidth], OffsetWidth'(0)};
  assign w_addr_o   = {addr_q[1][AddrWidth-1:OffsetWidth], OffsetWidth'(0)};
  assign r_len_o    = len[0];
  assign w_len_o    = len[1];
  assign r_offset_o = off[0];
  assign w_offset_o = off[1];
  assign r_tailer_o = tail[0];
  assign w_tailer_o = tail[1];
  assign r_valid_o  = valid_q[0];
  assign w_valid_o  = valid_q[1];
  assign w_last_o   = valid_q[1] & (rem_q[1] == bytes[1]);
  assign r_busy_o   = state_q[0] == ISSUE;
  assign w_busy_o   = state_q[1] == ISSUE;
endmodule

// File: tb/tb_idma_legalizer_rw_axi_flex.sv
// tb_idma_legalizer_rw_axi_flex: scoreboard bench for the AXI 1D legalizer.
module tb_idma_legalizer_rw_axi_flex;
  typedef struct packed {logic [31:0] addr; logic [7:0] len; logic [2:0] off; logic [2:0] tail; logic last;} burst_t;
  typedef struct {logic [31:0] src; logic [31:0] dst; int unsigned n; bit dec; int nr; int nw;} vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] req_src = '0, req_dst = '0, req_len = '0;
  logic req_dec = 1'b0, req_fixed = 1'b0, req_valid = 1'b0, req_ready;
  logic r_ready = 1'b0, w_ready = 1'b0, flush = 1'b0, kill = 1'b0;
  logic [31:0] r_addr, w_addr, m_r_addr, m_w_addr;
  logic [7:0] r_len, w_len, m_r_len, m_w_len;
  logic [2:0] r_offset, r_tailer, w_offset, w_tailer, m_r_offset, m_r_tailer, m_w_offset, m_w_tailer;
  logic r_valid, w_valid, w_last, r_busy, w_busy;
  logic m_req_ready, m_r_valid, m_w_valid, m_w_last, m_r_busy, m_w_busy;
  int passed = 0, total = 0, rcnt = 0, wcnt = 0, mrcnt = 0, mwcnt = 0;
  burst_t rq[$], wq[$], mrq[$], mwq[$];
  bit rnd = 0, mon16 = 0;
  vec_t vt[8];
  logic [46:0] snap;
  always #5 clk = ~clk;
  idma_legalizer_rw_axi_flex u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_src_addr_i(req_src), .req_dst_addr_i(req_dst),
    .req_length_i(req_len), .req_decouple_rw_i(req_dec), .req_fixed_i(req_fixed),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .r_addr_o(r_addr), .r_len_o(r_len), .r_offset_o(r_offset), .r_tailer_o(r_tailer),
    .r_valid_o(r_valid), .r_ready_i(r_ready),
    .w_addr_o(w_addr), .w_len_o(w_len), .w_offset_o(w_offset), .w_tailer_o(w_tailer),
    .w_last_o(w_last), .w_valid_o(w_valid), .w_ready_i(w_ready),
    .flush_i(flush), .kill_i(kill), .r_busy_o(r_busy), .w_busy_o(w_busy));
  idma_legalizer_rw_axi_flex #(.MaxBeats(16)) u_dut16 (
    .clk_i(clk), .rst_ni(rst_n), .req_src_addr_i(req_src), .req_dst_addr_i(req_dst),
    .req_length_i(req_len), .req_decouple_rw_i(req_dec), .req_fixed_i(req_fixed),
    .req_valid_i(req_valid), .req_ready_o(m_req_ready),
    .r_addr_o(m_r_addr), .r_len_o(m_r_len), .r_offset_o(m_r_offset), .r_tailer_o(m_r_tailer),
    .r_valid_o(m_r_valid), .r_ready_i(r_ready),
    .w_addr_o(m_w_addr), .w_len_o(m_w_len), .w_offset_o(m_w_offset), .w_tailer_o(m_w_tailer),
    .w_last_o(m_w_last), .w_valid_o(m_w_valid), .w_ready_i(w_ready),
    .flush_i(flush), .kill_i(kill), .r_busy_o(m_r_busy), .w_busy_o(m_w_busy));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask
  always @(negedge clk) if (rst_n) begin
    if (r_valid && r_ready) begin
      rcnt++;
      if (rq.size() == 0) chk("r_unexpected_burst", 1, 0);
      else chk("r_burst", 64'({r_addr, r_len, r_offset, r_tailer, 1'b0}), 64'(rq.pop_front()));
    end
    if (w_valid && w_ready) begin
      wcnt++;
      if (wq.size() == 0) chk("w_unexpected_burst", 1, 0);
      else chk("w_burst", 64'({w_addr, w_len, w_offset, w_tailer, w_last}), 64'(wq.pop_front()));
    end
    if (mon16 && m_r_valid && r_ready) begin
      mrcnt++;
      if (mrq.size() == 0) chk("m16_r_unexpected_burst", 1, 0);
      else chk("m16_r_burst", 64'({m_r_addr, m_r_len, m_r_offset, m_r_tailer, 1'b0}), 64'(mrq.pop_front()));
    end
    if (mon16 && m_w_valid && w_ready) begin
      mwcnt++;
      if (mwq.size() == 0) chk("m16_w_unexpected_burst", 1, 0);
      else chk("m16_w_burst", 64'({m_w_addr, m_w_len, m_w_offset, m_w_tailer, m_w_last}), 64'(mwq.pop_front()));
    end
  end
  function automatic int unsigned lim_of(input logic [31:0] a, input int unsigned bb, input bit fx);
    return fx ? 128 : bb - 32'(a % bb);
  endfunction
  task automatic push_xfer(input logic [31:0] s, input logic [31:0] d, input int unsigned n,
                           input bit dec, input bit fx, input bit m);
    int unsigned bb, rr, wr, rb, wb;
    logic [31:0] ra, wa;
    burst_t b;
    bb = m ? 128 : 2048; ra = s; wa = d; rr = n; wr = n;
    while (rr > 0 || wr > 0) begin
      rb = lim_of(ra, bb, fx);
      wb = lim_of(wa, bb, fx);
      if (!dec) begin rb = rb < wb ? rb : wb; wb = rb; end
      if (rb > rr) rb = rr;
      if (wb > wr) wb = wr;
      if (rr > 0) begin
        b = '{ra & ~32'h7, 8'((ra % 8 + rb - 1) / 8), 3'(ra % 8), 3'((ra + rb) % 8), 1'b0};
        if (m) mrq.push_back(b); else rq.push_back(b);
        if (!fx) ra = ra + rb;
        rr = rr - rb;
      end
      if (wr > 0) begin
        b = '{wa & ~32'h7, 8'((wa % 8 + wb - 1) / 8), 3'(wa % 8), 3'((wa + wb) % 8), wr == wb};
        if (m) mwq.push_back(b); else wq.push_back(b);
        if (!fx) wa = wa + wb;
        wr = wr - wb;
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    if (rnd) begin
      r_ready = 1'($urandom_range(0, 1));
      w_ready = 1'($urandom_range(0, 1));
      flush = $urandom_range(0, 7) == 0;
    end
  endtask
  task automatic send(input logic [31:0] s, input logic [31:0] d, input int unsigned n, input bit dec, input bit fx);
    push_xfer(s, d, n, dec, fx, 0);
    req_src = s; req_dst = d; req_len = n; req_dec = dec; req_fixed = fx; req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (req_ready) break;
      cyc();
    end
    chk("req_accept", req_ready, 1);
    cyc();
    req_valid = 1'b0; req_fixed = 1'b0;
  endtask
  task automatic drain(input string nm);
    for (int i = 0; i < 3000 && (rq.size() + wq.size() + mrq.size() + mwq.size() != 0
         || r_busy || w_busy || (mon16 && (m_r_busy || m_w_busy))); i++) cyc();
    chk(nm, rq.size() + wq.size() + mrq.size() + mwq.size() + r_busy + w_busy, 0);
  endtask
  initial begin
    vt[0] = '{32'h0, 32'h1000, 2048, 1'b0, 1, 1};
    vt[1] = '{32'hFF8, 32'h2000, 64, 1'b0, 2, 2};
    vt[2] = '{32'hFF8, 32'h2000, 64, 1'b1, 2, 1};
    vt[3] = '{32'h0, 32'h0, 16384, 1'b0, 8, 8};
    vt[4] = '{32'h13, 32'h7FD, 5000, 1'b1, 3, 4};
    vt[5] = '{32'h13, 32'h7FD, 5000, 1'b0, 6, 6};
    vt[6] = '{32'h7, 32'h3, 1, 1'b0, 1, 1};
    vt[7] = '{32'hFFFFFFF0, 32'h10, 64, 1'b0, 2, 2};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valids", {r_valid, w_valid}, 0);
    chk("rst_busy", {r_busy, w_busy}, 0);
    chk("rst_w_last", w_last, 0);
    chk("rst_addrs", {r_addr, w_addr}, 0);
    chk("rst_lens", {r_len, w_len}, 0);
    rst_n = 1'b1;
    cyc();
    r_ready = 1'b1; w_ready = 1'b1; rcnt = 0; wcnt = 0;
    send(32'h0, 32'h1000, 2048, 0, 0);
    chk("lat_valids", {r_valid, w_valid}, 2'b11);
    chk("lat_r_len", r_len, 255);
    chk("lat_w_last", w_last, 1);
    chk("lat_req_ready_completing", req_ready, 1);
    cyc();
    chk("single_idle", {r_busy, w_busy, r_valid, w_valid}, 0);
    rcnt = 0; wcnt = 0; r_ready = 1'b1; w_ready = 1'b0;
    send(32'hFF8, 32'h2000, 64, 1, 0);
    snap = {w_addr, w_len, w_offset, w_tailer, w_last};
    chk("dec_w_fields", snap, {32'h2000, 8'd7, 3'd0, 3'd0, 1'b1});
    for (int i = 0; i < 10; i++) begin
      chk("dec_w_stable", {w_valid, w_addr, w_len, w_offset, w_tailer, w_last}, {1'b1, snap});
      cyc();
    end
    chk("dec_r_done", {r_busy, r_valid}, 0);
    chk("dec_r_count", rcnt, 2);
    w_ready = 1'b1;
    drain("dec_drain");
    chk("dec_w_count", wcnt, 1);
    rcnt = 0; wcnt = 0; r_ready = 1'b1; w_ready = 1'b0;
    send(32'hFF8, 32'h2000, 64, 0, 0);
    chk("cpl_both_valid", {r_valid, w_valid}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("cpl_r_waits", {r_valid, w_valid, r_busy}, 3'b011);
    end
    chk("cpl_r_once", rcnt, 1);
    w_ready = 1'b1;
    cyc();
    chk("cpl_second_rise", {r_valid, w_valid, r_addr, r_len, w_addr}, {2'b11, 32'h1000, 8'd6, 32'h2008});
    drain("cpl_drain");
    chk("cpl_counts", {rcnt[7:0], wcnt[7:0]}, {8'd2, 8'd2});
    rnd = 1;
    for (int v = 0; v < 8; v++) begin
      rcnt = 0; wcnt = 0;
      send(vt[v].src, vt[v].dst, vt[v].n, vt[v].dec, 0);
      drain("vec_drain");
      chk("vec_r_count", rcnt, vt[v].nr);
      chk("vec_w_count", wcnt, vt[v].nw);
    end
    rnd = 0; r_ready = 1'b0; w_ready = 1'b0; flush = 1'b0;
    send(32'h0, 32'h0, 4096, 0, 0);
    flush = 1'b1;
    cyc();
    chk("flush_hold_valid", {r_valid, w_valid}, 2'b11);
    #1;
    chk("flush_req_ready", req_ready, 0);
    r_ready = 1'b1; w_ready = 1'b1;
    cyc();
    chk("flush_no_rise", {r_valid, w_valid, r_busy, w_busy}, 4'b0011);
    flush = 1'b0;
    cyc();
    chk("flush_release", {r_valid, w_valid}, 2'b11);
    drain("flush_drain");
    rcnt = 0;
    send(32'h0, 32'h0, 16384, 0, 0);
    cyc();
    cyc();
    kill = 1'b1;
    #1;
    chk("kill_req_ready", req_ready, 0);
    cyc();
    kill = 1'b0;
    chk("kill_idle", {r_valid, w_valid, r_busy, w_busy}, 0);
    chk("kill_r_count", rcnt, 3);
    chk("kill_left", rq.size(), 5);
    rq.delete(); wq.delete();
    rcnt = 0; wcnt = 0;
    send(32'h40, 32'h80, 8, 0, 0);
    drain("post_kill_drain");
    chk("post_kill_counts", {rcnt[7:0], wcnt[7:0]}, {8'd1, 8'd1});
    rcnt = 0; wcnt = 0;
    send(32'h0, 32'h0, 0, 0, 0);
    chk("zero_idle", {r_valid, w_valid, r_busy, w_busy}, 0);
    #1;
    chk("zero_ready", req_ready, 1);
    cyc();
    chk("zero_no_burst", rcnt + wcnt, 0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    mon16 = 1; mrcnt = 0; mwcnt = 0;
    push_xfer(32'h0, 32'h4000, 1024, 0, 0, 1);
    send(32'h0, 32'h4000, 1024, 0, 0);
    drain("m16_drain");
    chk("m16_counts", {mrcnt[7:0], mwcnt[7:0]}, {8'd8, 8'd8});
`ifdef IDMA_LEGALIZER_FIXED_BURST_EN
    mrcnt = 0; mwcnt = 0; rcnt = 0;
    push_xfer(32'h100, 32'h300, 1024, 0, 1, 1);
    send(32'h100, 32'h300, 1024, 0, 1);
    drain("fixed_drain");
    chk("fixed_m16_counts", {mrcnt[7:0], mwcnt[7:0]}, {8'd8, 8'd8});
    chk("fixed_r_count", rcnt, 8);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
